// File: rtl/rf_pkg.sv
// Shared constants and the writeback entry type for the regfile writeback slice.
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NREG   = 1 << AW;

    localparam logic [AW-1:0] ZERO_REG = '0;

    // One pending regfile write: destination plus value.
    typedef struct packed {
        logic [AW-1:0]     waddr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; head is visible while not empty.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output wb_entry_t rd_entry,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // Storage write; contents are only meaningful between push and pop.
    // NOTE: the data array has no reset -- occupancy is tracked by count/pointers,
    // so clearing the storage would only cost flops without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless
    // of statement order; = here would make later lines see already-updated state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Regfile writeback controller: merges ALU and buffered LSU results onto the single
// write port, tracks long-latency destinations, and bypasses the in-flight write.
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [AW-1:0]     issue_rd,
    output logic [NREG-1:0]   busy_mask,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_waddr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW-1:0]     lsu_waddr,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    wb_entry_t       lsu_entry;
    wb_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            force_head;
    logic            alu_win;
    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    assign lsu_entry = '{waddr: lsu_waddr, data: lsu_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (lsu_entry),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Arbitration: a starved FIFO head pre-empts the ALU, otherwise ALU has priority.
    always_comb begin
        force_head = !fifo_empty && (starve_cnt == STARVE_MAX);
        alu_win    = resetn && alu_valid && !force_head;
        fifo_pop   = resetn && !fifo_empty && !alu_win;
        lsu_ready  = resetn && !fifo_full;
        fifo_push  = lsu_valid && lsu_ready;
        alu_ready  = alu_win;
    end

    // Starvation counter: counts cycles a waiting head loses, saturating at the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Output stage: register the winner; writes to register zero are suppressed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (alu_win) begin
            rf_we    <= (alu_waddr != ZERO_REG);
            rf_waddr <= alu_waddr;
            rf_wdata <= alu_data;
        end else if (fifo_pop) begin
            rf_we    <= (head.waddr != ZERO_REG);
            rf_waddr <= head.waddr;
            rf_wdata <= head.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard update masks: new long-latency issue sets, LSU pop clears.
    // NOTE: both masks get a default before the conditional bit writes, so no
    // path leaves them unassigned and no latch is inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_long && (issue_rd != ZERO_REG)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (fifo_pop) begin
            clr_mask[head.waddr] = 1'b1;
        end
    end

    // Scoreboard register: set is applied after clear so a same-cycle reissue wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign busy_mask = busy_q;

    // Bypass of the write the regfile commits at the coming edge.
    always_comb begin
        fwd_hit1  = rf_we && (rf_waddr == raddr1) && (raddr1 != ZERO_REG);
        fwd_hit2  = rf_we && (rf_waddr == raddr2) && (raddr2 != ZERO_REG);
        fwd_data1 = rf_wdata;
        fwd_data2 = rf_wdata;
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_rf_wb_ctrl;
    import rf_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              issue_valid, issue_long;
    logic [AW-1:0]     issue_rd;
    logic [NREG-1:0]   busy_mask;
    logic              alu_valid, alu_ready;
    logic [AW-1:0]     alu_waddr;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid, lsu_ready;
    logic [AW-1:0]     lsu_waddr;
    logic [DATA_W-1:0] lsu_data;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [AW-1:0]     raddr1, raddr2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;

    rf_wb_ctrl #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .busy_mask   (busy_mask),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_waddr   (alu_waddr),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_waddr   (lsu_waddr),
        .lsu_data    (lsu_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [NREG-1:0]   m_busy;
    int                m_lost;
    logic              m_we;
    logic [AW-1:0]     m_waddr;
    logic [DATA_W-1:0] m_wdata;
    bit                m_force, m_take_alu, m_take_lsu, m_put;
    ent_t              m_head;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_busy  = '0;
            m_lost  = 0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            m_force    = (mq.size() != 0) && (m_lost == STARVE_LIMIT);
            m_take_alu = alu_valid && !m_force;
            m_take_lsu = (mq.size() != 0) && !m_take_alu;
            m_put      = lsu_valid && (mq.size() < FIFO_DEPTH);
            if (m_take_alu) begin
                m_we    = (alu_waddr != 0);
                m_waddr = alu_waddr;
                m_wdata = alu_data;
            end else if (m_take_lsu) begin
                m_head  = mq.pop_front();
                m_we    = (m_head.a != 0);
                m_waddr = m_head.a;
                m_wdata = m_head.d;
                m_busy[m_head.a] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid && issue_long && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (m_take_lsu || (mq.size() == 0 && !m_put)) m_lost = 0;
            else if (mq.size() == 0) m_lost = 0;
            else if (m_lost < STARVE_LIMIT) m_lost++;
            if (m_put) mq.push_back('{lsu_waddr, lsu_data});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rf_we", rf_we, m_we);
            if (m_we) begin
                check("rf_waddr", rf_waddr, m_waddr);
                check("rf_wdata", rf_wdata, m_wdata);
            end
            check("busy_mask", busy_mask, m_busy);
            check("alu_ready", alu_ready,
                  resetn && alu_valid && !(mq.size() != 0 && m_lost == STARVE_LIMIT));
            check("lsu_ready", lsu_ready, resetn && (mq.size() < FIFO_DEPTH));
            check("fwd_hit1", fwd_hit1, m_we && m_waddr == raddr1 && raddr1 != 0);
            check("fwd_hit2", fwd_hit2, m_we && m_waddr == raddr2 && raddr2 != 0);
            if (m_we && m_waddr == raddr1 && raddr1 != 0) check("fwd_data1", fwd_data1, m_wdata);
            if (m_we && m_waddr == raddr2 && raddr2 != 0) check("fwd_data2", fwd_data2, m_wdata);
        end
    end

    // Log of every regfile write the DUT presents.
    ent_t wlog[$];
    always @(negedge clk) begin
        if (resetn === 1'b1 && rf_we === 1'b1) wlog.push_back('{rf_waddr, rf_wdata});
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_data = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic push_lsu(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        lsu_valid = 1'b1; lsu_waddr = a; lsu_data = d;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = rd;
    endtask

    int forced, accepted;
    int n_lsu_seen, n_alu_seen;

    initial begin
        idle();
        resetn = 1'b0;

        // Reset with every input active.
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_data = 32'h1;
        push_lsu(5'd4, 32'h44);
        issue(5'd8);
        raddr1 = 5'd5;
        repeat (3) tick();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_busy", busy_mask, '0);
        check("reset_lsu_ready", lsu_ready, 1'b0);
        check("reset_alu_ready", alu_ready, 1'b0);
        check("reset_rf_waddr", rf_waddr, '0);
        check("reset_rf_wdata", rf_wdata, '0);
        tick();
        idle();
        resetn = 1'b1;
        @(negedge clk);
        check("release_lsu_ready", lsu_ready, 1'b1);

        // ALU latency and bypass.
        tick();
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("alu_accept", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
        @(negedge clk);
        check("alu_lat_we", rf_we, 1'b1);
        check("alu_lat_waddr", rf_waddr, 5'd5);
        check("alu_lat_wdata", rf_wdata, 32'hDEADBEEF);
        check("alu_fwd_hit1", fwd_hit1, 1'b1);
        check("alu_fwd_data1", fwd_data1, 32'hDEADBEEF);
        check("alu_fwd_hit2", fwd_hit2, 1'b0);
        tick();
        raddr1 = '0; raddr2 = '0;

        // Scoreboard set and clear.
        issue(5'd8);
        tick();
        idle();
        @(negedge clk);
        check("sb_set8", busy_mask[8], 1'b1);
        tick();
        push_lsu(5'd8, 32'h1234);
        tick();
        lsu_valid = 1'b0;
        tick();
        @(negedge clk);
        check("sb_lsu_we", rf_we, 1'b1);
        check("sb_lsu_waddr", rf_waddr, 5'd8);
        check("sb_lsu_wdata", rf_wdata, 32'h1234);
        check("sb_clear8", busy_mask[8], 1'b0);

        // Same-cycle set and clear: set wins.
        tick();
        issue(5'd8);
        tick();
        idle();
        push_lsu(5'd8, 32'hAAAA);
        tick();
        lsu_valid = 1'b0;
        issue(5'd8);
        tick();
        idle();
        @(negedge clk);
        check("sb_setwins_wdata", rf_wdata, 32'hAAAA);
        check("sb_setwins8", busy_mask[8], 1'b1);
        tick();
        push_lsu(5'd8, 32'hBBBB);
        tick();
        lsu_valid = 1'b0;
        tick();
        @(negedge clk);
        check("sb_final_clear8", busy_mask[8], 1'b0);

        // Contention: ALU valid every cycle while two LSU results queue up.
        tick();
        wlog.delete();
        forced = 0;
        accepted = 0;
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_data = 32'h100;
        for (int i = 0; i < 14; i++) begin
            lsu_valid = (i < 2);
            lsu_waddr = (i == 0) ? 5'd10 : 5'd11;
            lsu_data  = (i == 0) ? 32'hA0 : 32'hB0;
            @(negedge clk);
            if (i == 2) check("cont_full_lsu_ready", lsu_ready, 1'b0);
            if (alu_ready) begin
                accepted++;
                tick();
                alu_data = alu_data + 1;
            end else begin
                forced++;
                if (forced == 1) check("cont_first_force_cycle", i, 5);
                if (forced == 2) check("cont_second_force_cycle", i, 10);
                tick();
            end
        end
        idle();
        repeat (3) tick();
        check("cont_forced_pops", forced, 2);
        check("cont_alu_accepts", accepted, 12);
        n_lsu_seen = 0;
        n_alu_seen = 0;
        foreach (wlog[k]) begin
            if (wlog[k].a == 5'd7) begin
                check("cont_alu_order", wlog[k].d, 32'h100 + n_alu_seen);
                n_alu_seen++;
            end else begin
                check("cont_lsu_addr", wlog[k].a, (n_lsu_seen == 0) ? 5'd10 : 5'd11);
                check("cont_lsu_data", wlog[k].d, (n_lsu_seen == 0) ? 32'hA0 : 32'hB0);
                n_lsu_seen++;
            end
        end
        check("cont_alu_writes", n_alu_seen, 12);
        check("cont_lsu_writes", n_lsu_seen, 2);

        // Register zero is never written, never busy, never forwarded.
        wlog.delete();
        alu_valid = 1'b1; alu_waddr = '0; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("zero_alu_we", rf_we, 1'b0);
        tick();
        push_lsu('0, 32'h66);
        issue('0);
        raddr1 = '0;
        tick();
        idle();
        tick();
        @(negedge clk);
        check("zero_lsu_we", rf_we, 1'b0);
        check("zero_busy0", busy_mask[0], 1'b0);
        check("zero_fwd_hit1", fwd_hit1, 1'b0);
        check("zero_no_writes", wlog.size(), 0);

        // Reset mid-flight with a full FIFO and busy bits 3 and 9.
        tick();
        issue(5'd3);
        tick();
        issue(5'd9);
        tick();
        idle();
        alu_valid = 1'b1; alu_waddr = 5'd12; alu_data = 32'h77;
        push_lsu(5'd3, 32'h33);
        tick();
        push_lsu(5'd9, 32'h99);
        tick();
        lsu_valid = 1'b0;
        @(negedge clk);
        check("mid_busy3", busy_mask[3], 1'b1);
        check("mid_busy9", busy_mask[9], 1'b1);
        check("mid_fifo_full", lsu_ready, 1'b0);
        tick();
        idle();
        resetn = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", busy_mask, '0);
        check("mid_reset_we", rf_we, 1'b0);
        tick();
        resetn = 1'b1;
        wlog.delete();
        repeat (6) tick();
        @(negedge clk);
        check("mid_after_busy", busy_mask, '0);
        check("mid_after_lsu_ready", lsu_ready, 1'b1);
        check("mid_after_no_writes", wlog.size(), 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
